uart_line_echo: RTL

//  Line-buffered echo stage between uart_rx and uart_tx.
//  - Collects received bytes into a line buffer.
//  - On CR (0x0D) or a full buffer, replays the line to the transmitter, followed by CR LF.
//  - Replaces the free-running byte echo in the top level; gives whole-line echo with flow control.

---
 rtl/uart_line_echo_if.sv | 28 ++
 rtl/uart_line_echo.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/uart_line_echo_if.sv
// Byte-stream handshake bundle between uart_rx, the line echo stage and uart_tx.
// The echo stage uses the slave view; the surrounding logic uses the master view.
interface uart_line_echo_if;
   logic [7:0] rx_data;
   logic       rx_data_valid;
   logic       rx_data_ready;
   logic [7:0] tx_data;
   logic       tx_data_valid;
   logic       tx_data_ready;

   modport slave (
      input  rx_data,
      input  rx_data_valid,
      output rx_data_ready,
      output tx_data,
      output tx_data_valid,
      input  tx_data_ready
   );

   modport master (
      output rx_data,
      output rx_data_valid,
      input  rx_data_ready,
      input  tx_data,
      input  tx_data_valid,
      output tx_data_ready
   );
endinterface

// File: rtl/uart_line_echo.sv
// Line-buffered echo: collects rx bytes, replays the line plus CR LF on terminator or full buffer.
// Optional build macro LINE_ECHO_UPPERCASE_EN folds 'a'..'z' to upper case on replay.
//
// state     | meaning
// COLLECT   | accepting rx bytes into the line buffer
// SEND_LINE | presenting buffered bytes to tx, one per transfer
// SEND_CR   | presenting 0x0D
// SEND_LF   | presenting 0x0A, then clear the line
module uart_line_echo #(
   parameter int         DEPTH     = 32,
   parameter logic [7:0] TERM_CHAR = 8'h0D
) (
   input  logic                 clk,
   input  logic                 rst_n,
   uart_line_echo_if.slave      io,
   output logic [7:0]           line_len,
   output logic                 busy,
   output logic                 overflow
);

   localparam int         IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [7:0] DEPTH_B = 8'(DEPTH);
   localparam logic [7:0] CR_BYTE = 8'h0D;
   localparam logic [7:0] LF_BYTE = 8'h0A;

   typedef enum logic [1:0] {
      COLLECT,
      SEND_LINE,
      SEND_CR,
      SEND_LF
   } state_t;

   state_t     state;
   state_t     state_nxt;
   logic [7:0] buf_mem [DEPTH];
   logic [7:0] rd_idx;
   logic       collect;
   logic       rx_acc;
   logic       tx_xfer;
   logic       is_term;
   logic       is_lf;
   logic       store_en;
   logic       last_byte;
   logic [7:0] raw_byte;
   logic [7:0] line_byte;

   // Handshake outputs come straight from the state register so the reset
   // path forces valid low and ready high without waiting for a clock.
   assign collect          = (state == COLLECT);
   assign busy             = !collect;
   assign io.rx_data_ready = collect;
   assign io.tx_data_valid = busy;

   assign rx_acc    = io.rx_data_valid && collect;
   assign tx_xfer   = io.tx_data_ready && busy;
   assign is_term   = (io.rx_data == TERM_CHAR);
   assign is_lf     = (io.rx_data == LF_BYTE);
   assign store_en  = rx_acc && !is_term && !is_lf;
   assign last_byte = (rd_idx == (line_len - 8'd1));

   assign raw_byte = buf_mem[rd_idx[IDX_W-1:0]];

   always_comb begin
      line_byte = raw_byte;
`ifdef LINE_ECHO_UPPERCASE_EN
      if ((raw_byte >= 8'h61) && (raw_byte <= 8'h7A)) begin
         line_byte = raw_byte - 8'h20;
      end
`endif
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= COLLECT;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt  = state;
      io.tx_data = 8'h00;
      case (state)
         COLLECT: begin
            if (rx_acc) begin
               if (is_term) begin
                  state_nxt = (line_len == 8'd0) ? SEND_CR : SEND_LINE;
               end else if (!is_lf && ((line_len + 8'd1) == DEPTH_B)) begin
                  state_nxt = SEND_LINE;
               end
            end
         end
         SEND_LINE: begin
            io.tx_data = line_byte;
            if (tx_xfer && last_byte) begin
               state_nxt = SEND_CR;
            end
         end
         SEND_CR: begin
            io.tx_data = CR_BYTE;
            if (tx_xfer) begin
               state_nxt = SEND_LF;
            end
         end
         SEND_LF: begin
            io.tx_data = LF_BYTE;
            if (tx_xfer) begin
               state_nxt = COLLECT;
            end
         end
         default: begin
            state_nxt = COLLECT;
         end
      endcase
   end

   // Buffer storage is not reset; line_len alone marks which entries are live.
   always_ff @(posedge clk) begin
      if (store_en) begin
         buf_mem[line_len[IDX_W-1:0]] <= io.rx_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         line_len <= 8'd0;
         rd_idx   <= 8'd0;
         overflow <= 1'b0;
      end else begin
         overflow <= 1'b0;
         if (store_en) begin
            line_len <= line_len + 8'd1;
            overflow <= ((line_len + 8'd1) == DEPTH_B);
         end
         if ((state == SEND_LINE) && tx_xfer) begin
            rd_idx <= rd_idx + 8'd1;
         end
         if ((state == SEND_LF) && tx_xfer) begin
            line_len <= 8'd0;
            rd_idx   <= 8'd0;
         end
      end
   end

endmodule
